top_desgin_module: RTL and testbench
====================================

TOP_DESGIN_MODULE -- requirements
Module: top_desgin_module

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; reset port name follows codebase naming (rstN) but polarity is active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rstN  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 randA  input  6  hash multiplier coefficient, unsigned.
REQ-005 randB  input  6  hash additive coefficient, unsigned.
REQ-006 kmersSeqOne  input  4x6 (packed [3:0][5:0])  four 6-bit k-mer codes of sequence one, unsigned.
REQ-007 kmersSeqTwo  input  4x6 (packed [3:0][5:0])  four 6-bit k-mer codes of sequence two, unsigned.
REQ-008 jaccardSimilarity  output  3  registered MinHash similarity estimate, 0..4 (count of matches in last 4 evaluations).

Function
REQ-009 Hash per k-mer x: h(x) = (randA*x + randB) mod 64; full-width 12-bit product, low 6 bits of the sum kept, no saturation.
REQ-010 Inputs (randA, randB, both k-mer vectors) SHALL be sampled on every rising clk edge with reset deasserted; there is no handshake, one evaluation per cycle.
REQ-011 Stage 1 (edge N): the 8 hashes (4 per sequence) SHALL be registered, with a valid bit set to 1.
REQ-012 Stage 2 (edge N+1): minOne = unsigned minimum of the 4 seq-one hashes, minTwo = minimum of the 4 seq-two hashes SHALL be registered; match = (minOne == minTwo); valid propagates.
REQ-013 Stage 3 (edge N+2): if stage-2 valid, the match bit SHALL shift into bit 0 of a 4-bit window (oldest bit dropped) and a window-fill counter (0..4) SHALL increment, saturating at 4.
REQ-014 At edge N+2 jaccardSimilarity SHALL take the population count of the updated window; latency from input sample to output = 3 rising edges.
REQ-015 Window bits not yet filled since reset SHALL be 0, so the output never counts invalid slots; the output never exceeds 4.
REQ-016 Duplicate k-mers within a sequence are permitted; min reduction is applied unchanged.
REQ-017 Changing randA/randB between cycles SHALL be allowed; each evaluation uses the coefficients sampled with its own k-mers.
REQ-018 randA = 0 SHALL yield all hashes = randB, therefore match = 1.
REQ-019 Ties in the min reduction need no special handling (only the value matters).

Reset
REQ-020 With rstN = 1 at a rising edge, all hash registers, min registers, valid bits, the window, the fill counter and jaccardSimilarity SHALL be cleared to 0 at that edge.
REQ-021 Reset asserted mid-operation SHALL discard all in-flight evaluations; after release, the first sample at edge N produces its first nonzero contribution at edge N+2.
REQ-022 Output value while reset is held SHALL be 0.

Verification
REQ-023 Identical sets {10,5,20,21}, randA=30, randB=15: hashes 59,37,39,5, both minima 5, match; held constant -> output 1,2,3,4 at edges N+2..N+5, then stays 4.
REQ-024 Identical sets {10,5,20,21}, randA=23, randB=10 after the previous case: match every cycle, output remains 4 through the coefficient change.
REQ-025 seqOne {10,5,20,21}, seqTwo {1,2,3,4}, randA=1, randB=0: minima 5 vs 1, no match; output stays 0 from reset onward.
REQ-026 Alternate the matching case (REQ-023) and the non-matching case (REQ-025) each cycle: once filled, output settles at 2.
REQ-027 Reach output 4, assert rstN for one edge: output 0 at that edge; after release with matching inputs, output reaches 1 three edges after the first post-reset sample.
REQ-028 randA=0, randB=37, arbitrary different sets: match every cycle, output ramps to 4.

Source files
------------

// File: rtl/top_desgin_module.sv
// MinHash similarity estimator: three-stage pipeline that hashes two k-mer sets,
// compares their minima and reports how many of the last four evaluations matched.
module top_desgin_module (
  input  logic            clk,
  input  logic            rstN,
  input  logic [5:0]      randA,
  input  logic [5:0]      randB,
  input  logic [3:0][5:0] kmersSeqOne,
  input  logic [3:0][5:0] kmersSeqTwo,
  output logic [2:0]      jaccardSimilarity
);

  // Full 12-bit product, then the 6-bit sum wraps naturally to give mod 64.
  function automatic logic [5:0] hashKmer(input logic [5:0] a, input logic [5:0] b,
                                          input logic [5:0] x);
    logic [11:0] prod;
    prod = {6'd0, a} * {6'd0, x};
    return prod[5:0] + b;
  endfunction

  function automatic logic [5:0] minOfFour(input logic [3:0][5:0] v);
    logic [5:0] m;
    m = v[0];
    for (int i = 1; i < 4; i++) begin
      if (v[i] < m) m = v[i];
    end
    return m;
  endfunction

  logic [3:0][5:0] hashOne_q, hashOne_d;
  logic [3:0][5:0] hashTwo_q, hashTwo_d;
  logic            valid1_q, valid1_d;
  logic [5:0]      minOne_q, minOne_d;
  logic [5:0]      minTwo_q, minTwo_d;
  logic            valid2_q, valid2_d;
  logic [3:0]      window_q, window_d;
  logic [2:0]      fill_q, fill_d;
  logic [2:0]      similarity_q, similarity_d;
  logic [3:0]      fillMask;

  always_comb begin
    hashOne_d = '0;
    hashTwo_d = '0;
    for (int i = 0; i < 4; i++) begin
      hashOne_d[i] = hashKmer(randA, randB, kmersSeqOne[i]);
      hashTwo_d[i] = hashKmer(randA, randB, kmersSeqTwo[i]);
    end
    valid1_d = 1'b1;

    minOne_d = minOfFour(hashOne_q);
    minTwo_d = minOfFour(hashTwo_q);
    valid2_d = valid1_q;
  end

  // Slots not yet filled since reset are masked so they can never be counted.
  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    if (valid2_q) begin
      window_d = {window_q[2:0], (minOne_q == minTwo_q)};
      fill_d   = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
    end
    fillMask = '0;
    for (int i = 0; i < 4; i++) begin
      fillMask[i] = (3'(i) < fill_d);
    end
    similarity_d = 3'd0;
    for (int i = 0; i < 4; i++) begin
      similarity_d = similarity_d + {2'd0, window_d[i] & fillMask[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rstN) begin
      hashOne_q    <= '0;
      hashTwo_q    <= '0;
      valid1_q     <= 1'b0;
      minOne_q     <= '0;
      minTwo_q     <= '0;
      valid2_q     <= 1'b0;
      window_q     <= '0;
      fill_q       <= '0;
      similarity_q <= '0;
    end else begin
      hashOne_q    <= hashOne_d;
      hashTwo_q    <= hashTwo_d;
      valid1_q     <= valid1_d;
      minOne_q     <= minOne_d;
      minTwo_q     <= minTwo_d;
      valid2_q     <= valid2_d;
      window_q     <= window_d;
      fill_q       <= fill_d;
      similarity_q <= similarity_d;
    end
  end

  assign jaccardSimilarity = similarity_q;

endmodule

// File: tb/tb_top_desgin_module.sv
// Bench for the MinHash similarity pipeline: directed scenarios plus randomized
// traffic compared against a sample-history model of the windowed match count.
module tb_top_desgin_module;

  logic            clk = 1'b0;
  logic            rstN;
  logic [5:0]      randA;
  logic [5:0]      randB;
  logic [3:0][5:0] kmersSeqOne;
  logic [3:0][5:0] kmersSeqTwo;
  logic [2:0]      jaccardSimilarity;

  int checks = 0;
  int failures = 0;
  int expOut = 0;
  bit hist[$];

  logic [3:0][5:0] setMatch;
  logic [3:0][5:0] setOther;

  always #5 clk = ~clk;

  top_desgin_module dut (
    .clk              (clk),
    .rstN             (rstN),
    .randA            (randA),
    .randB            (randB),
    .kmersSeqOne      (kmersSeqOne),
    .kmersSeqTwo      (kmersSeqTwo),
    .jaccardSimilarity(jaccardSimilarity)
  );

  function automatic bit refMatch(input int a, input int b,
                                  input logic [3:0][5:0] s1, input logic [3:0][5:0] s2);
    int m1, m2, h;
    m1 = 1000;
    m2 = 1000;
    for (int i = 0; i < 4; i++) begin
      h = (a * int'(s1[i]) + b) % 64;
      if (h < m1) m1 = h;
      h = (a * int'(s2[i]) + b) % 64;
      if (h < m2) m2 = h;
    end
    return m1 == m2;
  endfunction

  // One clock edge; the output after edge k counts matches among samples up to
  // edge k-2 since the last reset, limited to the four most recent.
  task automatic cycle(input bit r, input logic [5:0] a, input logic [5:0] b,
                       input logic [3:0][5:0] s1, input logic [3:0][5:0] s2);
    int usable;
    rstN = r;
    randA = a;
    randB = b;
    kmersSeqOne = s1;
    kmersSeqTwo = s2;
    @(posedge clk);
    if (r) hist.delete();
    else hist.push_back(refMatch(int'(a), int'(b), s1, s2));
    expOut = 0;
    usable = hist.size() - 2;
    for (int i = 0; i < usable; i++) begin
      if (i >= usable - 4 && hist[i]) expOut++;
    end
    @(negedge clk);
  endtask

  function automatic logic [3:0][5:0] randSet();
    logic [3:0][5:0] s;
    for (int i = 0; i < 4; i++) s[i] = 6'($urandom_range(0, 63));
    return s;
  endfunction

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 6'($urandom), 6'($urandom), randSet(), randSet());
      checks++;
      if (jaccardSimilarity !== 3'd0) begin
        failures++;
        $display("[TB] FAIL reset_hold cycle=%0d got=%0d want=0", k, jaccardSimilarity);
      end
    end
  endtask

  task automatic test_identical();
    int want;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 6'd30, 6'd15, setMatch, setMatch);
      want = (k < 2) ? 0 : ((k - 1 > 4) ? 4 : k - 1);
      checks++;
      if (jaccardSimilarity !== 3'(want)) begin
        failures++;
        $display("[TB] FAIL identical_ramp cycle=%0d got=%0d want=%0d", k, jaccardSimilarity, want);
      end
    end
  endtask

  task automatic test_coeff_change();
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 6'd23, 6'd10, setMatch, setMatch);
      checks++;
      if (jaccardSimilarity !== 3'd4) begin
        failures++;
        $display("[TB] FAIL coeff_change cycle=%0d got=%0d want=4", k, jaccardSimilarity);
      end
    end
  endtask

  task automatic test_no_match();
    cycle(1'b1, 6'd1, 6'd0, setMatch, setOther);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 6'd1, 6'd0, setMatch, setOther);
      checks++;
      if (jaccardSimilarity !== 3'd0) begin
        failures++;
        $display("[TB] FAIL no_match cycle=%0d got=%0d want=0", k, jaccardSimilarity);
      end
    end
  endtask

  task automatic test_alternate();
    cycle(1'b1, 6'd0, 6'd0, setMatch, setMatch);
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) cycle(1'b0, 6'd30, 6'd15, setMatch, setMatch);
      else cycle(1'b0, 6'd1, 6'd0, setMatch, setOther);
      checks++;
      if (k >= 5 && jaccardSimilarity !== 3'd2) begin
        failures++;
        $display("[TB] FAIL alternate_settle cycle=%0d got=%0d want=2", k, jaccardSimilarity);
      end else if (k < 5 && jaccardSimilarity !== 3'(expOut)) begin
        failures++;
        $display("[TB] FAIL alternate_fill cycle=%0d got=%0d want=%0d", k, jaccardSimilarity, expOut);
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 6'd30, 6'd15, setMatch, setMatch);
    for (int k = 0; k < 6; k++) cycle(1'b0, 6'd30, 6'd15, setMatch, setMatch);
    checks++;
    if (jaccardSimilarity !== 3'd4) begin
      failures++;
      $display("[TB] FAIL mid_reset_full got=%0d want=4", jaccardSimilarity);
    end
    cycle(1'b1, 6'd30, 6'd15, setMatch, setMatch);
    checks++;
    if (jaccardSimilarity !== 3'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset_clear got=%0d want=0", jaccardSimilarity);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 6'd30, 6'd15, setMatch, setMatch);
      checks++;
      if (jaccardSimilarity !== 3'((k < 2) ? 0 : k - 1)) begin
        failures++;
        $display("[TB] FAIL mid_reset_restart cycle=%0d got=%0d want=%0d", k, jaccardSimilarity,
                 (k < 2) ? 0 : k - 1);
      end
    end
  endtask

  task automatic test_randa_zero();
    int want;
    cycle(1'b1, 6'd0, 6'd37, randSet(), randSet());
    for (int k = 0; k < 7; k++) begin
      cycle(1'b0, 6'd0, 6'd37, randSet(), randSet());
      want = (k < 2) ? 0 : ((k - 1 > 4) ? 4 : k - 1);
      checks++;
      if (jaccardSimilarity !== 3'(want)) begin
        failures++;
        $display("[TB] FAIL randa_zero cycle=%0d got=%0d want=%0d", k, jaccardSimilarity, want);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0][5:0] s1, s2;
    bit r;
    for (int k = 0; k < 300; k++) begin
      s1 = randSet();
      if ($urandom_range(0, 1) == 1) begin
        s2 = s1;
        s2[$urandom_range(0, 3)] = 6'($urandom_range(0, 63));
      end else begin
        s2 = randSet();
      end
      r = ($urandom_range(0, 19) == 0);
      cycle(r, 6'($urandom), 6'($urandom), s1, s2);
      checks++;
      if (jaccardSimilarity !== 3'(expOut)) begin
        failures++;
        $display("[TB] FAIL random cycle=%0d got=%0d want=%0d", k, jaccardSimilarity, expOut);
      end
    end
  endtask

  initial begin
    setMatch = {6'd21, 6'd20, 6'd5, 6'd10};
    setOther = {6'd4, 6'd3, 6'd2, 6'd1};
    rstN = 1'b1;
    randA = '0;
    randB = '0;
    kmersSeqOne = '0;
    kmersSeqTwo = '0;
    @(negedge clk);
    test_reset();
    test_identical();
    test_coeff_change();
    test_no_match();
    test_alternate();
    test_reset_mid();
    test_randa_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
